// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frogger_pkg
//  Description : Shared types and constants for the frogger scoring logic:
//                scorer FSM state encoding and active-low 7-segment codes.
//  Revision    : 1.0  initial release
// ============================================================================
package frogger_pkg;

    // Scorer FSM states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        RESPAWN = 2'd1,
        WON     = 2'd2
    } score_state_t;

    // All segments dark (active-low)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segment codes for digits 0..9, bit0=a .. bit6=g
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage
`default_nettype wire

// File: rtl/score_keeper_if.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper_if
//  Description : Bundle between the point detector / board logic and the
//                score keeper: point input, respawn/win status, score digits
//                and 7-segment drives.
//  Revision    : 1.0  initial release
// ============================================================================
interface score_keeper_if;
    logic       point;
    logic       respawn;
    logic       win;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic [6:0] hex0;
    logic [6:0] hex1;

    // Game side: produces points, consumes status and display
    modport master (
        output point,
        input  respawn, win, score_ones, score_tens, hex0, hex1
    );

    // Score keeper side
    modport slave (
        input  point,
        output respawn, win, score_ones, score_tens, hex0, hex1
    );
endinterface
`default_nettype wire

// File: rtl/score_keeper_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : BCD digit to active-low 7-segment decode. Codes 10..15
//                cannot occur in normal operation and blank the display.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decoder
    import frogger_pkg::*;
(
    input  wire logic [3:0] i_bcd,
    output logic      [6:0] o_seg
);

    // Table lookup for legal digits, blank for anything else
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_bcd <= 4'd9) begin
            o_seg = SEG_DIGIT[i_bcd];
        end
    end

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper
//  Description : Two-digit BCD score counter driven by point pulses. Each
//                point triggers a respawn pulse train; reaching WIN_SCORE
//                freezes the game in WON until reset.
//  Revision    : 1.0  initial release
// ============================================================================
module score_keeper
    import frogger_pkg::*;
#(
    parameter int WIN_SCORE      = 10,  // 0 = endless play, score wraps 99->00
    parameter int RESPAWN_CYCLES = 4    // 1..255
)(
    input  wire logic     clk,
    input  wire logic     reset,        // synchronous, active-low
    score_keeper_if.slave sk
);

    localparam logic [3:0] c_WIN_ONES     = 4'(WIN_SCORE % 10);
    localparam logic [3:0] c_WIN_TENS     = 4'(WIN_SCORE / 10);
    localparam logic       c_WIN_ENABLE   = (WIN_SCORE != 0);
    localparam logic [7:0] c_RESPAWN_LOAD = 8'(RESPAWN_CYCLES - 1);

    score_state_t r_state, w_state_nxt;
    logic [3:0]   r_ones, r_tens;
    logic [3:0]   w_ones_nxt, w_tens_nxt;
    logic [7:0]   r_cnt, w_cnt_nxt;
    logic [3:0]   w_inc_ones, w_inc_tens;
    logic         w_hit_win;

    // BCD +1 with carry; tens wraps 9->0 so 99 rolls over to 00
    always_comb begin
        w_inc_ones = r_ones + 4'd1;
        w_inc_tens = r_tens;
        if (r_ones == 4'd9) begin
            w_inc_ones = 4'd0;
            w_inc_tens = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
        end
        w_hit_win = c_WIN_ENABLE && (w_inc_ones == c_WIN_ONES)
                                 && (w_inc_tens == c_WIN_TENS);
    end

    // Next-state logic: score only moves on a point seen in PLAY
    always_comb begin
        w_state_nxt = r_state;
        w_ones_nxt  = r_ones;
        w_tens_nxt  = r_tens;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            PLAY: begin
                if (sk.point) begin
                    w_ones_nxt = w_inc_ones;
                    w_tens_nxt = w_inc_tens;
                    if (w_hit_win) begin
                        w_state_nxt = WON;
                    end else begin
                        w_state_nxt = RESPAWN;
                        w_cnt_nxt   = c_RESPAWN_LOAD;
                    end
                end
            end
            RESPAWN: begin
                // points arriving here are dropped
                if (r_cnt == 8'd0) begin
                    w_state_nxt = PLAY;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            WON: begin
                w_state_nxt = WON;
            end
            default: begin
                w_state_nxt = PLAY;
            end
        endcase
    end

    // State, score and respawn counter registers; reset wins over point
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= PLAY;
            r_ones  <= 4'd0;
            r_tens  <= 4'd0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ones  <= w_ones_nxt;
            r_tens  <= w_tens_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Status flags decode straight from the state register (no path from point)
    assign sk.respawn    = (r_state == RESPAWN);
    assign sk.win        = (r_state == WON);
    assign sk.score_ones = r_ones;
    assign sk.score_tens = r_tens;

    seg7_decoder u_seg_ones (
        .i_bcd (r_ones),
        .o_seg (sk.hex0)
    );

    seg7_decoder u_seg_tens (
        .i_bcd (r_tens),
        .o_seg (sk.hex1)
    );

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Directed self-checking bench for score_keeper. dut_a uses
//                WIN_SCORE=10, dut_b uses WIN_SCORE=0 (endless play).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_score_keeper;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [7:0] exp_q [$];

    score_keeper_if ifa ();
    score_keeper_if ifb ();

    score_keeper #(.WIN_SCORE(10), .RESPAWN_CYCLES(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .sk    (ifa)
    );

    score_keeper #(.WIN_SCORE(0), .RESPAWN_CYCLES(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .sk    (ifb)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // One-cycle point pulse on the selected DUT; the expected score is queued
    // when the pulse is driven and checked once the edge has taken it
    task automatic pulse(input bit sel_b, input logic [7:0] exp_score, input string tag);
        logic [7:0] e;
        exp_q.push_back(exp_score);
        if (sel_b) ifb.point = 1'b1; else ifa.point = 1'b1;
        tick();
        ifa.point = 1'b0;
        ifb.point = 1'b0;
        e = exp_q.pop_front();
        if (sel_b) chk(tag, {24'd0, ifb.score_tens, ifb.score_ones}, {24'd0, e});
        else       chk(tag, {24'd0, ifa.score_tens, ifa.score_ones}, {24'd0, e});
    endtask

    initial begin
        logic [7:0] e;
        n_tests   = 0;
        n_fail    = 0;
        ifa.point = 1'b0;
        ifb.point = 1'b0;
        reset     = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (5) tick();

        // Reset state
        chk("rst_score", {24'd0, ifa.score_tens, ifa.score_ones}, 32'h00);
        chk("rst_hex0",  {25'd0, ifa.hex0}, {25'd0, 7'b1000000});
        chk("rst_hex1",  {25'd0, ifa.hex1}, {25'd0, 7'b1000000});
        chk("rst_respawn", {31'd0, ifa.respawn}, 32'd0);
        chk("rst_win",   {31'd0, ifa.win}, 32'd0);
        chk("rst_b_score", {24'd0, ifb.score_tens, ifb.score_ones}, 32'h00);

        // Single point: visible next cycle, respawn for 4 cycles
        pulse(1'b0, 8'h01, "p1_score");
        chk("p1_respawn_c1", {31'd0, ifa.respawn}, 32'd1);
        chk("p1_hex0", {25'd0, ifa.hex0}, {25'd0, 7'b1111001});
        // Point during RESPAWN is dropped
        pulse(1'b0, 8'h01, "respawn_ignore");
        chk("p1_respawn_c2", {31'd0, ifa.respawn}, 32'd1);
        tick();
        chk("p1_respawn_c3", {31'd0, ifa.respawn}, 32'd1);
        tick();
        chk("p1_respawn_c4", {31'd0, ifa.respawn}, 32'd1);
        tick();
        chk("p1_respawn_end", {31'd0, ifa.respawn}, 32'd0);

        // Pulses spaced by 6 cycles up to 9
        for (int i = 2; i <= 9; i++) begin
            pulse(1'b0, to_bcd(i), "count");
            repeat (5) tick();
        end
        chk("nine_tens", {28'd0, ifa.score_tens}, 32'd0);
        chk("nine_ones", {28'd0, ifa.score_ones}, 32'd9);

        // Tenth point wins; no respawn
        pulse(1'b0, 8'h10, "win_score");
        chk("win_flag", {31'd0, ifa.win}, 32'd1);
        chk("win_respawn", {31'd0, ifa.respawn}, 32'd0);
        chk("win_hex1", {25'd0, ifa.hex1}, {25'd0, 7'b1111001});
        chk("win_hex0", {25'd0, ifa.hex0}, {25'd0, 7'b1000000});
        pulse(1'b0, 8'h10, "won_frozen1");
        tick();
        pulse(1'b0, 8'h10, "won_frozen2");
        chk("won_hold", {31'd0, ifa.win}, 32'd1);

        // Reset in WON with a simultaneous point
        reset = 1'b0;
        ifa.point = 1'b1;
        tick();
        reset = 1'b1;
        ifa.point = 1'b0;
        chk("rst_won_score", {24'd0, ifa.score_tens, ifa.score_ones}, 32'h00);
        chk("rst_won_win", {31'd0, ifa.win}, 32'd0);
        chk("rst_won_respawn", {31'd0, ifa.respawn}, 32'd0);

        // point held high 20 cycles: one count per 5 cycles
        ifa.point = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(to_bcd(k / 5 + 1));
            tick();
            e = exp_q.pop_front();
            chk("hold_score", {24'd0, ifa.score_tens, ifa.score_ones}, {24'd0, e});
            chk("hold_respawn", {31'd0, ifa.respawn}, {31'd0, ((k % 5) != 4)});
        end
        ifa.point = 1'b0;

        // Reset in mid-RESPAWN with a simultaneous point
        pulse(1'b0, 8'h05, "pre_rst_score");
        tick();
        reset = 1'b0;
        ifa.point = 1'b1;
        tick();
        reset = 1'b1;
        ifa.point = 1'b0;
        chk("rst_rsp_score", {24'd0, ifa.score_tens, ifa.score_ones}, 32'h00);
        chk("rst_rsp_respawn", {31'd0, ifa.respawn}, 32'd0);
        chk("rst_rsp_win", {31'd0, ifa.win}, 32'd0);
        pulse(1'b0, 8'h01, "post_rst_play");
        chk("post_rst_respawn", {31'd0, ifa.respawn}, 32'd1);

        // Endless play: 100 spaced points wrap 99 -> 00, no win
        repeat (5) tick();
        for (int i = 1; i <= 100; i++) begin
            pulse(1'b1, to_bcd(i % 100), "endless");
            chk("endless_nowin", {31'd0, ifb.win}, 32'd0);
            repeat (5) tick();
        end
        chk("wrap_hex0", {25'd0, ifb.hex0}, {25'd0, 7'b1000000});
        chk("wrap_hex1", {25'd0, ifb.hex1}, {25'd0, 7'b1000000});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
